// File: rtl/fp_pkg.sv
// Shared types and constants for the binary64 round-and-pack stage.
package fp_pkg;

    localparam int EW   = 11;
    localparam int FW   = 52;
    localparam int BIAS = 1023;
    localparam int SW   = FW + 5;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RZ  = 2'b01,
        RM_RU  = 2'b10,
        RM_RD  = 2'b11
    } rm_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_NORM  = 2'b01,
        S_ROUND = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    localparam int FL_ZERO = 56;
    localparam int FL_INV  = 55;
    localparam int FL_INF  = 54;
    localparam int FL_NAN  = 53;

    localparam logic [12:0]   QNAN_PREFIX = 13'h0FFF;
    localparam logic [EW-1:0] INF_EXP     = 11'h7FF;
    localparam logic [62:0]   MAX_FINITE  = {11'h7FE, 52'hF_FFFF_FFFF_FFFF};

    function automatic logic round_inc(input rm_e mode, input logic sign,
                                       input logic lsb, input logic [2:0] grs);
        logic inexact;
        inexact = |grs;
        case (mode)
            RM_RNE:  round_inc = grs[2] & (grs[1] | grs[0] | lsb);
            RM_RZ:   round_inc = 1'b0;
            RM_RU:   round_inc = ~sign & inexact;
            RM_RD:   round_inc = sign & inexact;
            default: round_inc = 1'b0;
        endcase
    endfunction

    // Overflow saturates to infinity only when rounding points away from zero.
    function automatic logic ovf_to_inf(input rm_e mode, input logic sign);
        case (mode)
            RM_RNE:  ovf_to_inf = 1'b1;
            RM_RZ:   ovf_to_inf = 1'b0;
            RM_RU:   ovf_to_inf = ~sign;
            RM_RD:   ovf_to_inf = sign;
            default: ovf_to_inf = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lzc56.sv
// Combinational leading-zero counter over 56 bits; count is 56 when all bits are zero.
module lzc56 (
    input  logic [55:0] d_i,
    output logic [5:0]  cnt_o,
    output logic        zero_o
);

    // Scan upward so the highest set bit is written last and wins.
    always_comb begin
        cnt_o = 6'd56;
        for (int i = 0; i < 56; i++) begin
            cnt_o = d_i[i] ? 6'(55 - i) : cnt_o;
        end
        zero_o = ~|d_i;
    end

endmodule

// File: rtl/fp_round_pack.sv
// Normalize, round and pack an unrounded adder sum into an IEEE-754 binary64 word.
// Build option DENORM_EN: gradual underflow; when undefined, tiny results flush to signed zero.
module fp_round_pack
    import fp_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] in_es,
    input  logic [SW-1:0] in_fs,
    input  logic          in_ss,
    input  logic [SW-1:0] in_fl,
    input  logic [1:0]    rm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    output logic [3:0]    out_exc
);

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [63:0]        out_data_q, out_data_d;
    logic [3:0]         out_exc_q, out_exc_d;
    logic [SW-1:0]      fs_q, fs_d;
    logic signed [12:0] exp_q, exp_d;
    logic               ss_q, ss_d;
    logic [SW-1:0]      fl_q, fl_d;
    rm_e                rm_q, rm_d;
    logic               zero_q, zero_d;
    logic               tiny_q, tiny_d;

    logic [5:0]         lz_cnt;
    logic               lz_zero;
    logic [SW-1:0]      n_fs, dn_fs;
    logic signed [12:0] n_exp, dn_exp;
    logic               n_zero, dn_tiny;

    logic               inexact, inc, r_ovf, flush_s;
    logic [53:0]        r_sum;
    logic [FW-1:0]      r_frac;
    logic signed [12:0] r_exp;
    logic [63:0]        pack_data;
    logic [3:0]         pack_exc;
    logic               unused_fl;

    // Payload bits above the quiet-NaN field are replaced by the quiet bit.
    assign unused_fl = ^fl_q[52:51];

    lzc56 u_lzc (
        .d_i    (fs_q[55:0]),
        .cnt_o  (lz_cnt),
        .zero_o (lz_zero)
    );

    // Normalize: absorb a carry-out, or shift the leading one up to the hidden position.
    always_comb begin
        n_zero = lz_zero & ~fs_q[56];
        if (fs_q[56]) begin
            n_fs  = {1'b0, fs_q[56:2], fs_q[1] | fs_q[0]};
            n_exp = exp_q + 13'sd1;
        end else begin
            n_fs  = fs_q << lz_cnt;
            n_exp = exp_q - $signed({7'd0, lz_cnt});
        end
    end

`ifdef DENORM_EN
    logic signed [12:0] dn_amt;
    logic [5:0]         dn_sh;
    logic [SW-1:0]      dn_mask;

    // Denormalize tiny values onto the exponent-0 grid, folding lost bits into sticky.
    always_comb begin
        dn_amt  = 13'sd1 - n_exp;
        dn_sh   = (dn_amt > 13'sd56) ? 6'd56 : dn_amt[5:0];
        dn_mask = (57'd1 << dn_sh) - 57'd1;
        if ((n_exp < 13'sd1) && !n_zero) begin
            dn_fs   = (n_fs >> dn_sh) | {56'd0, |(n_fs & dn_mask)};
            dn_exp  = 13'sd0;
            dn_tiny = 1'b1;
        end else begin
            dn_fs   = n_fs;
            dn_exp  = n_exp;
            dn_tiny = 1'b0;
        end
    end

    assign flush_s = 1'b0;
`else
    // Without gradual underflow a tiny value is only flagged here and flushed at pack time.
    always_comb begin
        dn_fs   = n_fs;
        dn_exp  = n_exp;
        dn_tiny = (n_exp < 13'sd1) && !n_zero;
    end

    assign flush_s = tiny_q;
`endif

    // Round the 53-bit significand and renormalize on carry-out.
    always_comb begin
        inexact = |fs_q[2:0];
        inc     = round_inc(rm_q, ss_q, fs_q[3], fs_q[2:0]);
        r_sum   = {1'b0, fs_q[55:3]} + {53'd0, inc};
        if (r_sum[53]) begin
            r_frac = r_sum[52:1];
            r_exp  = exp_q + 13'sd1;
        end else if ((exp_q == 13'sd0) && r_sum[52]) begin
            r_frac = r_sum[51:0];
            r_exp  = 13'sd1;
        end else begin
            r_frac = r_sum[51:0];
            r_exp  = exp_q;
        end
        r_ovf = (r_exp >= 13'sd2047);
    end

    // Pack the result; special-case flags override the arithmetic path.
    always_comb begin
        pack_data = 64'd0;
        pack_exc  = 4'd0;
        if (fl_q[FL_NAN]) begin
            pack_data = {QNAN_PREFIX, fl_q[FW-2:0]};
            pack_exc  = {fl_q[FL_INV], 3'b000};
        end else if (fl_q[FL_INF]) begin
            pack_data = {ss_q, INF_EXP, 52'd0};
            pack_exc  = {fl_q[FL_INV], 3'b000};
        end else if (fl_q[FL_ZERO] || zero_q) begin
            pack_data = {ss_q, 63'd0};
            pack_exc  = {fl_q[FL_INV], 3'b000};
        end else if (flush_s) begin
            pack_data = {ss_q, 63'd0};
            pack_exc  = {fl_q[FL_INV], 3'b011};
        end else if (r_ovf) begin
            pack_data = ovf_to_inf(rm_q, ss_q) ? {ss_q, INF_EXP, 52'd0} : {ss_q, MAX_FINITE};
            pack_exc  = {fl_q[FL_INV], 3'b101};
        end else begin
            pack_data = {ss_q, r_exp[EW-1:0], r_frac};
            pack_exc  = {fl_q[FL_INV], 1'b0, tiny_q & inexact, inexact};
        end
    end

    // Next-state and datapath-capture logic for the four-phase sequence.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_exc_d   = out_exc_q;
        fs_d        = fs_q;
        exp_d       = exp_q;
        ss_d        = ss_q;
        fl_d        = fl_q;
        rm_d        = rm_q;
        zero_d      = zero_q;
        tiny_d      = tiny_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    fs_d    = in_fs;
                    exp_d   = $signed({2'b00, in_es});
                    ss_d    = in_ss;
                    fl_d    = in_fl;
                    rm_d    = rm_e'(rm);
                    state_d = S_NORM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NORM: begin
                fs_d    = dn_fs;
                exp_d   = dn_exp;
                zero_d  = n_zero;
                tiny_d  = dn_tiny;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                out_data_d  = pack_data;
                out_exc_d   = pack_exc;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 64'd0;
            out_exc_q   <= 4'd0;
            fs_q        <= '0;
            exp_q       <= 13'sd0;
            ss_q        <= 1'b0;
            fl_q        <= '0;
            rm_q        <= RM_RNE;
            zero_q      <= 1'b0;
            tiny_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_exc_q   <= out_exc_d;
            fs_q        <= fs_d;
            exp_q       <= exp_d;
            ss_q        <= ss_d;
            fl_q        <= fl_d;
            rm_q        <= rm_d;
            zero_q      <= zero_d;
            tiny_q      <= tiny_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_exc   = out_exc_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: directed corner cases plus random sums
// checked against an exact-remainder rounding model.
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_es;
    logic [56:0] in_fs;
    logic        in_ss;
    logic [56:0] in_fl;
    logic [1:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_exc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_round_pack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_es     (in_es),
        .in_fs     (in_fs),
        .in_ss     (in_ss),
        .in_fl     (in_fl),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_exc   (out_exc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Value = fs * 2^(es-1078); round it to the binary64 grid using the exact discarded remainder.
    function automatic void model(input logic [10:0] es, input logic [56:0] fs, input logic ss,
                                  input logic [56:0] fl, input logic [1:0] mode,
                                  output logic [63:0] d, output logic [3:0] x);
        logic         inv, tiny, inexact, up;
        int           p, e, drop;
        logic [127:0] q, rem, half;
        inv = fl[55];
        p = -1;
        for (int i = 0; i < 57; i++) if (fs[i]) p = i;
        if (fl[53]) begin
            d = {1'b0, 11'h7FF, 1'b1, fl[50:0]};
            x = {inv, 3'b000};
            return;
        end
        if (fl[54]) begin
            d = {ss, 11'h7FF, 52'd0};
            x = {inv, 3'b000};
            return;
        end
        if (fl[56] || p < 0) begin
            d = {ss, 63'd0};
            x = {inv, 3'b000};
            return;
        end
        e = int'(es) + p - 55;
        tiny = (e < 1);
`ifndef DENORM_EN
        if (tiny) begin
            d = {ss, 63'd0};
            x = {inv, 3'b011};
            return;
        end
`endif
        drop = p - 52 + (tiny ? 1 - e : 0);
        if (drop <= 0) begin
            q = 128'(fs) << (-drop);
            rem = 128'd0;
            half = 128'd0;
        end else begin
            q = 128'(fs) >> drop;
            rem = 128'(fs) & ((128'd1 << drop) - 128'd1);
            half = 128'd1 << (drop - 1);
        end
        inexact = (rem != 128'd0);
        case (mode)
            2'd0:    up = inexact && ((rem > half) || (rem == half && q[0]));
            2'd1:    up = 1'b0;
            2'd2:    up = inexact && !ss;
            default: up = inexact && ss;
        endcase
        q = q + 128'(up);
        if (tiny) begin
            d = {ss, 10'd0, q[52], q[51:0]};
            x = {inv, 1'b0, inexact, inexact};
            return;
        end
        if (q[53]) begin
            q = q >> 1;
            e++;
        end
        if (e >= 2047) begin
            if (mode == 2'd0 || (mode == 2'd2 && !ss) || (mode == 2'd3 && ss))
                d = {ss, 11'h7FF, 52'd0};
            else
                d = {ss, 11'h7FE, 52'hF_FFFF_FFFF_FFFF};
            x = {inv, 3'b101};
        end else begin
            d = {ss, 11'(e), q[51:0]};
            x = {inv, 2'b00, inexact};
        end
    endfunction

    // One transaction: accept, check latency, check result (held for 'hold' cycles), release.
    task automatic run_op(input string tag, input logic [10:0] es, input logic [56:0] fs,
                          input logic ss, input logic [56:0] fl, input logic [1:0] mode,
                          input int hold, input logic [63:0] exp_d, input logic [3:0] exp_x);
        int lat;
        @(negedge clk);
        chk({tag, "/ready"}, 64'(in_ready), 64'd1);
        in_es = es; in_fs = fs; in_ss = ss; in_fl = fl; rm = mode; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; rm = ~mode; in_fs = ~fs; in_ss = ~ss;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), 64'd3);
        @(negedge clk);
        chk({tag, "/data"}, out_data, exp_d);
        chk({tag, "/exc"}, 64'(out_exc), 64'(exp_x));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_data"}, out_data, exp_d);
            chk({tag, "/hold_exc"}, 64'(out_exc), 64'(exp_x));
            chk({tag, "/hold_vr"}, 64'({out_valid, in_ready}), 64'h2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "/release"}, 64'({out_valid, in_ready}), 64'h1);
    endtask

    initial begin
        logic [63:0] md;
        logic [3:0]  mx;
        logic [56:0] fs_r, fl_r;
        logic [10:0] es_r;
        logic        ss_r;
        logic [1:0]  rm_r;
        logic [63:0] exp_tiny;
        logic [3:0]  exc_tiny;

        rst = 1'b1; in_valid = 1'b0; in_es = 11'd0; in_fs = 57'd0; in_ss = 1'b0;
        in_fl = 57'd0; rm = 2'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vr", 64'({out_valid, in_ready}), 64'h1);
        chk("reset_data", out_data, 64'd0);
        chk("reset_exc", 64'(out_exc), 64'd0);
        rst = 1'b0;

        run_op("carry", 11'd1023, 57'd1 << 56, 1'b0, 57'd0, 2'd0, 0, 64'h4000000000000000, 4'b0000);
        run_op("tie_rne", 11'd1023, (57'd1 << 55) | 57'd4, 1'b0, 57'd0, 2'd0, 0, 64'h3FF0000000000000, 4'b0001);
        run_op("tie_ru", 11'd1023, (57'd1 << 55) | 57'd4, 1'b0, 57'd0, 2'd2, 0, 64'h3FF0000000000001, 4'b0001);
        run_op("tie_rd", 11'd1023, (57'd1 << 55) | 57'd4, 1'b1, 57'd0, 2'd3, 0, 64'hBFF0000000000001, 4'b0001);
        run_op("ovf_rne", 11'd2046, 57'd1 << 56, 1'b0, 57'd0, 2'd0, 0, 64'h7FF0000000000000, 4'b0101);
        run_op("ovf_rz", 11'd2046, 57'd1 << 56, 1'b0, 57'd0, 2'd1, 0, 64'h7FEFFFFFFFFFFFFF, 4'b0101);
        run_op("nan", 11'd5, 57'd7, 1'b1, {4'b0101, 53'h1_2345_6789_ABCD}, 2'd0, 0,
               64'h7FF923456789ABCD, 4'b1000);
        run_op("zero_flag", 11'd1023, 57'd1 << 55, 1'b1, 57'd1 << 56, 2'd0, 0, 64'h8000000000000000, 4'b0000);
        run_op("fs_zero", 11'd1500, 57'd0, 1'b1, 57'd0, 2'd3, 0, 64'h8000000000000000, 4'b0000);
`ifdef DENORM_EN
        exp_tiny = 64'h0008000000000000;
        exc_tiny = 4'b0000;
`else
        exp_tiny = 64'h0000000000000000;
        exc_tiny = 4'b0011;
`endif
        run_op("tiny", 11'd1, 57'd1 << 54, 1'b0, 57'd0, 2'd0, 0, exp_tiny, exc_tiny);
        run_op("hold", 11'd1023, 57'd1 << 56, 1'b0, 57'd0, 2'd0, 5, 64'h4000000000000000, 4'b0000);

        // Reset while the item sits in NORM must discard it.
        @(negedge clk);
        in_es = 11'd1023; in_fs = 57'd1 << 56; in_ss = 1'b0; in_fl = 57'd0; rm = 2'd0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_vr", 64'({out_valid, in_ready}), 64'h1);
        chk("rst_mid_data", out_data, 64'd0);
        chk("rst_mid_exc", 64'(out_exc), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(out_valid), 64'd0);
        end

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 2))
                0:       es_r = 11'($urandom_range(0, 60));
                1:       es_r = 11'($urandom_range(990, 1060));
                default: es_r = 11'($urandom_range(1990, 2047));
            endcase
            fs_r = 57'({$urandom(), $urandom()}) >> $urandom_range(0, 56);
            ss_r = 1'($urandom_range(0, 1));
            rm_r = 2'($urandom_range(0, 3));
            fl_r = 57'd0;
            case ($urandom_range(0, 15))
                0:       fl_r = {4'b0001, 53'({$urandom(), $urandom()})};
                1:       fl_r = 57'd1 << 54;
                2:       fl_r = 57'd1 << 56;
                3:       fl_r = 57'd1 << 55;
                default: fl_r = 57'd0;
            endcase
            model(es_r, fs_r, ss_r, fl_r, rm_r, md, mx);
            run_op($sformatf("rand%0d", k), es_r, fs_r, ss_r, fl_r, rm_r, 0, md, mx);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
